// File: rtl/lift_req_queue.sv
// Hall-call request front end: per-button trackers feed an in-order FIFO of request codes.
// Define LIFT_REQ_DEBOUNCE_EN to replace rise detection with a DEB_CYCLES hold-time debounce.
module lift_req_queue #(
    parameter int DEPTH      = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] btn,
    input  logic       done,
    output logic [2:0] din,
    output logic       qEmpty,
    output logic [5:0] lamp,
    output logic [3:0] count
);
    // state   | meaning
    // IDLE    | no request outstanding for this button
    // LATCHED | press captured, waiting for a FIFO slot
    // QUEUED  | code sits in the FIFO, cleared when popped
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LATCHED = 2'd1,
        QUEUED  = 2'd2
    } trk_t;

    localparam logic [2:0] LAST    = 3'(DEPTH - 1);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
        $error("lift_req_queue: DEPTH out of range");
    end
    if (DEB_CYCLES < 2 || DEB_CYCLES > 15) begin : g_bad_deb
        $error("lift_req_queue: DEB_CYCLES out of range");
    end

    function automatic logic [2:0] code_of(input logic [2:0] idx);
        case (idx)
            3'd0:    code_of = 3'b001;
            3'd1:    code_of = 3'b010;
            3'd2:    code_of = 3'b011;
            3'd3:    code_of = 3'b110;
            3'd4:    code_of = 3'b111;
            3'd5:    code_of = 3'b100;
            default: code_of = 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] idx_of(input logic [2:0] code);
        case (code)
            3'b001:  idx_of = 3'd0;
            3'b010:  idx_of = 3'd1;
            3'b011:  idx_of = 3'd2;
            3'b110:  idx_of = 3'd3;
            3'b111:  idx_of = 3'd4;
            3'b100:  idx_of = 3'd5;
            default: idx_of = 3'd7;
        endcase
    endfunction

    trk_t       trk     [6];
    trk_t       trk_nxt [6];
    logic [5:0] press;
    logic [5:0] pend;
    logic [5:0] pend_nxt;
    logic [2:0] mem [8];
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic [3:0] cnt;
    logic       pop;
    logic       full;
    logic       ins_en;
    logic       found;
    logic [2:0] ins_idx;
    logic [2:0] pop_idx;

`ifdef LIFT_REQ_DEBOUNCE_EN
    localparam logic [3:0] DEB_MAX = 4'(DEB_CYCLES);
    logic [3:0] hold [6];

    // Counter parks at DEB_MAX so a long hold yields a single recognition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) hold[i] <= 4'd0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (!btn[i])
                    hold[i] <= 4'd0;
                else if (hold[i] != DEB_MAX)
                    hold[i] <= hold[i] + 4'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 6; i++)
            press[i] = btn[i] && (hold[i] == DEB_MAX - 4'd1);
    end
`else
    logic [5:0] btn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) btn_q <= 6'd0;
        else     btn_q <= btn;
    end

    assign press = btn & ~btn_q;
`endif

    assign pop     = done && (cnt != 4'd0);
    assign full    = (cnt == DEPTH_C);
    assign pop_idx = idx_of(mem[rd_ptr]);

    // Descending scan so the lowest-index latched button wins.
    always_comb begin
        found   = 1'b0;
        ins_idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (trk[i] == LATCHED) begin
                found   = 1'b1;
                ins_idx = 3'(i);
            end
        end
        ins_en = found && (!full || pop);
    end

    // A press landing on the edge that pops the same button is remembered in pend.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            trk_nxt[i]  = trk[i];
            pend_nxt[i] = 1'b0;
            case (trk[i])
                IDLE:    if (press[i] || pend[i]) trk_nxt[i] = LATCHED;
                LATCHED: if (ins_en && ins_idx == 3'(i)) trk_nxt[i] = QUEUED;
                QUEUED: begin
                    if (pop && pop_idx == 3'(i)) begin
                        trk_nxt[i]  = IDLE;
                        pend_nxt[i] = press[i];
                    end
                end
                default: trk_nxt[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) trk[i] <= IDLE;
            pend   <= 6'd0;
            wr_ptr <= 3'd0;
            rd_ptr <= 3'd0;
            cnt    <= 4'd0;
        end else begin
            for (int i = 0; i < 6; i++) trk[i] <= trk_nxt[i];
            pend <= pend_nxt;
            if (ins_en) wr_ptr <= (wr_ptr == LAST) ? 3'd0 : wr_ptr + 3'd1;
            if (pop)    rd_ptr <= (rd_ptr == LAST) ? 3'd0 : rd_ptr + 3'd1;
            case ({ins_en, pop})
                2'b10:   cnt <= cnt + 4'd1;
                2'b01:   cnt <= cnt - 4'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ins_en) mem[wr_ptr] <= code_of(ins_idx);
    end

    always_comb begin
        for (int i = 0; i < 6; i++) lamp[i] = (trk[i] != IDLE);
    end

    assign count  = cnt;
    assign qEmpty = (cnt == 4'd0);
    assign din    = (cnt != 4'd0) ? mem[rd_ptr] : 3'b000;

endmodule

// File: tb/tb_lift_req_queue.sv
// Scoreboard bench for lift_req_queue: a DEPTH=8 instance for most scenarios, DEPTH=2 for the full-FIFO case.
module tb_lift_req_queue;
`ifdef LIFT_REQ_DEBOUNCE_EN
    localparam int HOLD = 4;
`else
    localparam int HOLD = 1;
`endif

    logic       clk;
    logic       rst;
    logic [5:0] btn, btn2;
    logic       done, done2;
    logic [2:0] din, din2;
    logic       q_empty, q_empty2;
    logic [5:0] lamp, lamp2;
    logic [3:0] count, count2;

    int checks = 0;
    int errors = 0;
    logic [2:0] sb [$];
    logic [2:0] sb2 [$];
    logic [2:0] exp_code;

    lift_req_queue #(.DEPTH(8), .DEB_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .btn(btn), .done(done),
        .din(din), .qEmpty(q_empty), .lamp(lamp), .count(count)
    );

    lift_req_queue #(.DEPTH(2), .DEB_CYCLES(4)) dut2 (
        .clk(clk), .rst(rst), .btn(btn2), .done(done2),
        .din(din2), .qEmpty(q_empty2), .lamp(lamp2), .count(count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [5:0] b);
        btn = b;
        repeat (HOLD) tick();
        btn = 6'd0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        done = 1'b1;
        while ((sb.size() > 0 || !q_empty) && n < 60) begin
            if (!q_empty) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL drain_extra: got din=%b want empty", din);
                end else begin
                    exp_code = sb.pop_front();
                    if (din !== exp_code) begin
                        errors++;
                        $display("FAIL drain_order: got din=%b want %b", din, exp_code);
                    end
                end
            end
            tick();
            n++;
        end
        done = 1'b0;
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({count, q_empty, din, lamp} !== {4'd0, 1'b1, 3'b000, 6'd0}) begin
            errors++;
            $display("FAIL reset: got cnt=%0d e=%b din=%b lamp=%b want 0 1 000 000000", count, q_empty, din, lamp);
        end
        checks++;
        if ({count2, q_empty2, lamp2} !== {4'd0, 1'b1, 6'd0}) begin
            errors++;
            $display("FAIL reset2: got cnt=%0d e=%b lamp=%b want 0 1 000000", count2, q_empty2, lamp2);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        press(6'b000010);
        checks++;
        if (lamp !== 6'b000010 || q_empty !== 1'b1) begin
            errors++;
            $display("FAIL single_e0: got lamp=%b e=%b want 000010 1", lamp, q_empty);
        end
        sb.push_back(3'b010);
        tick();
        checks++;
        if (din !== 3'b010 || q_empty !== 1'b0) begin
            errors++;
            $display("FAIL single_e1: got din=%b e=%b want 010 0", din, q_empty);
        end
        drain();
        checks++;
        if (q_empty !== 1'b1 || din !== 3'b000 || lamp !== 6'd0) begin
            errors++;
            $display("FAIL single_pop: got e=%b din=%b lamp=%b want 1 000 000000", q_empty, din, lamp);
        end
    endtask

    task automatic test_order();
        sb.push_back(3'b001);
        sb.push_back(3'b111);
        sb.push_back(3'b100);
        press(6'b110001);
        repeat (3) tick();
        checks++;
        if (count !== 4'd3 || lamp !== 6'b110001) begin
            errors++;
            $display("FAIL order_count: got cnt=%0d lamp=%b want 3 110001", count, lamp);
        end
        drain();
    endtask

    task automatic test_dedup();
        sb.push_back(3'b011);
        press(6'b000100);
        tick();
        press(6'b000100);
        tick();
        checks++;
        if (count !== 4'd1 || lamp !== 6'b000100) begin
            errors++;
            $display("FAIL dedup: got cnt=%0d lamp=%b want 1 000100", count, lamp);
        end
        drain();
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("FAIL dedup_drain: got cnt=%0d want 0", count);
        end
    endtask

    task automatic test_back_to_back();
        sb.push_back(3'b001);
        sb.push_back(3'b010);
        sb.push_back(3'b011);
        press(6'b000011);
        repeat (2) tick();
        press(6'b000100);
        done = 1'b1;
        exp_code = sb.pop_front();
        checks++;
        if (din !== exp_code) begin
            errors++;
            $display("FAIL b2b_head: got din=%b want %b", din, exp_code);
        end
        tick();
        done = 1'b0;
        checks++;
        if (count !== 4'd2 || din !== 3'b010) begin
            errors++;
            $display("FAIL b2b_count: got cnt=%0d din=%b want 2 010", count, din);
        end
        drain();
    endtask

`ifndef LIFT_REQ_DEBOUNCE_EN
    task automatic test_repress_on_pop();
        press(6'b000010);
        tick();
        btn  = 6'b000010;
        done = 1'b1;
        checks++;
        if (din !== 3'b010) begin
            errors++;
            $display("FAIL repress_head: got din=%b want 010", din);
        end
        tick();
        btn  = 6'd0;
        done = 1'b0;
        checks++;
        if (lamp !== 6'd0 || q_empty !== 1'b1) begin
            errors++;
            $display("FAIL repress_idle: got lamp=%b e=%b want 000000 1", lamp, q_empty);
        end
        tick();
        checks++;
        if (lamp !== 6'b000010) begin
            errors++;
            $display("FAIL repress_latch: got lamp=%b want 000010", lamp);
        end
        sb.push_back(3'b010);
        tick();
        checks++;
        if (din !== 3'b010 || q_empty !== 1'b0) begin
            errors++;
            $display("FAIL repress_queue: got din=%b e=%b want 010 0", din, q_empty);
        end
        drain();
    endtask
`else
    task automatic test_debounce();
        btn = 6'b000001;
        repeat (3) tick();
        btn = 6'd0;
        tick();
        checks++;
        if (lamp !== 6'd0) begin
            errors++;
            $display("FAIL deb_short: got lamp=%b want 000000", lamp);
        end
        btn = 6'b000001;
        repeat (3) tick();
        checks++;
        if (lamp !== 6'd0) begin
            errors++;
            $display("FAIL deb_early: got lamp=%b want 000000", lamp);
        end
        tick();
        checks++;
        if (lamp !== 6'b000001) begin
            errors++;
            $display("FAIL deb_hold: got lamp=%b want 000001", lamp);
        end
        btn = 6'd0;
        sb.push_back(3'b001);
        drain();
    endtask
`endif

    task automatic test_depth2_full();
        int n;
        logic [2:0] ord [6];
        ord = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b100};
        for (int i = 0; i < 6; i++) sb2.push_back(ord[i]);
        btn2 = 6'b111111;
        repeat (HOLD) tick();
        btn2 = 6'd0;
        repeat (3) tick();
        checks++;
        if (count2 !== 4'd2 || q_empty2 !== 1'b0 || din2 !== 3'b001 || lamp2 !== 6'b111111) begin
            errors++;
            $display("FAIL full2: got cnt=%0d e=%b din=%b lamp=%b want 2 0 001 111111", count2, q_empty2, din2, lamp2);
        end
        done2 = 1'b1;
        n = 0;
        while ((sb2.size() > 0 || !q_empty2) && n < 60) begin
            if (!q_empty2) begin
                checks++;
                if (sb2.size() == 0) begin
                    errors++;
                    $display("FAIL full2_extra: got din=%b want empty", din2);
                end else begin
                    exp_code = sb2.pop_front();
                    if (din2 !== exp_code || count2 > 4'd2) begin
                        errors++;
                        $display("FAIL full2_order: got din=%b cnt=%0d want %b <=2", din2, count2, exp_code);
                    end
                end
            end
            tick();
            n++;
        end
        done2 = 1'b0;
        checks++;
        if (n >= 60 || q_empty2 !== 1'b1 || lamp2 !== 6'd0) begin
            errors++;
            $display("FAIL full2_end: got left=%0d e=%b lamp=%b want 0 1 000000", sb2.size(), q_empty2, lamp2);
        end
    endtask

    task automatic test_reset_mid();
        press(6'b000111);
        repeat (3) tick();
        checks++;
        if (count !== 4'd3) begin
            errors++;
            $display("FAIL rstmid_pre: got cnt=%0d want 3", count);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (count !== 4'd0 || lamp !== 6'd0 || q_empty !== 1'b1 || din !== 3'b000) begin
            errors++;
            $display("FAIL rstmid: got cnt=%0d lamp=%b e=%b din=%b want 0 000000 1 000", count, lamp, q_empty, din);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst   = 1'b1;
        btn   = 6'd0;
        btn2  = 6'd0;
        done  = 1'b0;
        done2 = 1'b0;
        test_reset();
        test_single();
        test_order();
        test_dedup();
        test_back_to_back();
`ifndef LIFT_REQ_DEBOUNCE_EN
        test_repress_on_pop();
`else
        test_debounce();
`endif
        test_depth2_full();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lift_req_queue.md
# lift_req_queue

Hall-call request front end for the lift controller. Samples the six hall-call buttons, encodes each new press into the 3-bit request code, and buffers requests in order of arrival. It presents the head request on `din` with an empty flag `qEmpty`, and pops the head when the lift FSM signals `done`. It is the producer end of the `din`/`qEmpty`/`done` interface consumed by the lift FSM.

## Interface
- `DEPTH`, 8: FIFO entries; legal range 2..8.
- `DEB_CYCLES`, 4: debounce hold length in cycles; only used with `LIFT_REQ_DEBOUNCE_EN`; legal range 2..15.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `btn`  in  6  hall-call buttons, synchronous to `clk`.
  - bit order [0]=1U, [1]=2U, [2]=3U, [3]=2D, [4]=3D, [5]=4D.
- `done`  in  1  lift FSM is ready; the head entry is accepted on an edge where `done && !qEmpty`.
- `din`  out  3  head request code; 3'b000 when empty.
- `qEmpty`  out  1  high when the FIFO holds no entries.
- `lamp`  out  6  per-button pending indicator, same bit order as `btn`.
- `count`  out  4  number of FIFO entries, 0..DEPTH.

## Operation
- Request codes:
  - 1U=3'b001, 2U=3'b010, 3U=3'b011
  - 2D=3'b110, 3D=3'b111, 4D=3'b100
  - none=3'b000
- Each button has a 2-bit tracker with three states:
  - IDLE: no request outstanding.
  - LATCHED: press captured, not yet in the FIFO.
  - QUEUED: entry is in the FIFO.
- Press detection: a rising edge is `btn[i]` sampled 1 with the previous registered sample 0.
- Tracker transitions:
  - IDLE -> LATCHED on press.
  - A press while LATCHED or QUEUED is ignored (dedup). The lamp is already on.
  - LATCHED -> QUEUED when the insert scheduler selects it.
  - QUEUED -> IDLE when its entry is popped.
- Insert scheduler:
  - At most one insert per cycle.
  - Selects the lowest-index LATCHED button, provided the FIFO is not full.
  - Writes that button's code at the write pointer.
- Pop: on an edge with `done && !qEmpty`, advance the read pointer and return the popped button's tracker to IDLE.
- Simultaneous insert and pop: both take effect; `count` is unchanged.
- Insert into a full FIFO: allowed only if a pop occurs on the same edge.
- Full FIFO with no pop: LATCHED requests wait. No request is dropped.
- Pointer and count rules:
  - Pointers are 3-bit and wrap at DEPTH-1 -> 0.
  - `count` saturates by construction and never exceeds DEPTH.
- Outputs:
  - `lamp[i]` = tracker state != IDLE.
  - `din` = mem[rd_ptr] when `count`!=0, else 3'b000.
  - `qEmpty` = (`count`==0).

## Timing
- Reset values: trackers IDLE, pointers 0, `count`=0, `qEmpty`=1, `din`=3'b000, `lamp`=0, previous-sample register 0.
- Reset asserted mid-operation clears all queued and latched requests immediately. No pop occurs.
- Press latency, for a press sampled at edge E0:
  - `lamp[i]`=1 after E0.
  - Entry inserted at E1, so `qEmpty`=0 and `din` is valid after E1.
  - Each additional simultaneously latched button is delayed one further edge, in index order.
- Pop: entry removed at the accepting edge; the lamp clears after the same edge. The next head appears on `din` combinationally after that edge.
- `din` is stable while `qEmpty`=0 and no pop occurs.
- A press sampled on the same edge that pops that button's entry is treated as a new press: IDLE on that edge, LATCHED on the next rising edge.

## Configuration
- `LIFT_REQ_DEBOUNCE_EN` defined:
  - Each button has a 4-bit hold counter.
  - A press is recognised only when `btn[i]` has been sampled high for DEB_CYCLES consecutive edges. The counter resets on any low sample.
  - Only one recognition per high period.
  - Press latency grows by DEB_CYCLES-1 edges.
- Not defined: single-edge rise detection as above; no counters are synthesised.

## Test plan
- Reset, then press 2U (btn=6'b000010 for one cycle):
  - `lamp`=000010 after E0.
  - `din`=010 and `qEmpty`=0 after E1, with done held 0.
  - Raise done for one cycle -> `qEmpty`=1, `din`=000, `lamp`=0.
- Press 4D, 1U, and 3D simultaneously with done=0 -> FIFO order 001, 111, 100 over three edges; `count`=3.
- DEPTH=2, press all six buttons with done=0:
  - `count`=2, `qEmpty`=0, `din`=001, `lamp`=111111.
  - Hold done=1 -> pops in order 001, 010, 011, 110, 111, 100, then `qEmpty`=1.
- Re-press 3U while QUEUED -> no second entry; `count` stays 1.
- Assert `rst` mid-queue with `count`=3 -> `count`=0, `lamp`=0, `qEmpty`=1 without a clock edge.
- With `LIFT_REQ_DEBOUNCE_EN` and DEB_CYCLES=4:
  - A 3-cycle pulse on 1U -> no lamp.
  - A 4-cycle hold -> lamp set on the 4th edge.
